// File: rtl/vga_sync.sv
// Raster timing generator: scan counters, video window, active-low syncs and a per-frame strobe.
// Optional clk/2 pixel divider under VGA_CLKDIV_EN; syncs/video_on are registered from next-state counters.
module vga_sync #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       p_tick,
  output logic       frame_start
);

  localparam logic [9:0] H_MAX    = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_MAX    = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [9:0] h_q, v_q;
  logic [9:0] h_next, v_next;
  logic       tick;

`ifdef VGA_CLKDIV_EN
  logic div_q;

  always_ff @(posedge clk) begin
    if (rst) div_q <= 1'b0;
    else     div_q <= ~div_q;
  end

  assign tick = div_q;
`else
  assign tick = 1'b1;
`endif

  assign p_tick  = tick;
  assign pixel_x = h_q;
  assign pixel_y = v_q;

  always_comb begin
    h_next = h_q;
    v_next = v_q;
    if (tick) begin
      if (h_q == H_MAX) begin
        h_next = 10'd0;
        v_next = (v_q == V_MAX) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_next = h_q + 10'd1;
      end
    end
  end

  // Decoding next-state values keeps syncs aligned with the coordinates they accompany.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q         <= 10'd0;
      v_q         <= 10'd0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_q         <= h_next;
      v_q         <= v_next;
      hsync       <= !((h_next >= HS_START) && (h_next <= HS_END));
      vsync       <= !((v_next >= VS_START) && (v_next <= VS_END));
      video_on    <= (h_next < H_VIS) && (v_next < V_VIS);
      frame_start <= tick && (h_q == H_MAX) && (v_q == V_MAX);
    end
  end

endmodule
